// File: rtl/icache_direct_if.sv
// ---------------------------------------------------------------------------
// icache_direct_if
//   Line-refill bus between the instruction cache and main memory.
//
//   mem_req    cache -> mem  refill request, held until mem_ready
//   mem_addr   cache -> mem  line-aligned refill byte address
//   mem_ready  mem -> cache  one-cycle pulse, mem_rdata valid this cycle
//   mem_rdata  mem -> cache  full line, word 0 in bits [31:0]
//
//   Modports: master = cache side, slave = memory side.
// ---------------------------------------------------------------------------
interface icache_direct_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
);
    logic                     mem_req;
    logic [ADDR_W-1:0]        mem_addr;
    logic                     mem_ready;
    logic [32*LINE_WORDS-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//   Direct-mapped, read-only instruction cache between fetch and main memory.
//   A hit returns the instruction combinationally. A miss stalls fetch,
//   refills the whole line over the mem bus, spends one UPDATE cycle and then
//   replays the lookup with the current pc.
//
//   clk           system clock, all state updates on the rising edge
//   reset         asynchronous, active-low reset
//   fetch_valid   fetch requests an instruction this cycle
//   pc            instruction byte address, bits [1:0] ignored
//   instruction   instruction word, valid when fetch_valid & !icache_stall
//   icache_stall  fetch must hold pc and retry
//   flush         one-cycle pulse, invalidates all lines
//   mem           refill bus (icache_direct_if.master)
//   hit_count     lookups that hit (wraps)
//   miss_count    misses detected (wraps)
// ---------------------------------------------------------------------------
module icache_direct #(
    parameter int NUM_LINES  = 4,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_valid,
    input  logic [ADDR_W-1:0]    pc,
    output logic [31:0]          instruction,
    output logic                 icache_stall,
    input  logic                 flush,
    icache_direct_if.master      mem,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int LSB_W = 2 + OFF_W;              // byte offset within a line
    localparam int TAG_W = ADDR_W - LSB_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        UPDATE
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [31:0]          data_arr [NUM_LINES][LINE_WORDS];

    logic              flush_pending;  // flush seen while a refill was in flight
    logic [ADDR_W-1:0] line_addr;      // latched refill address, drives mem_addr

    // Lookup fields of the current pc.
    logic [OFF_W-1:0] offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    assign offset = pc[LSB_W-1:2];
    assign index  = pc[LSB_W+IDX_W-1:LSB_W];
    assign tag    = pc[ADDR_W-1:LSB_W+IDX_W];

    // Fields of the line being refilled; taken from the latched address so a
    // pc change while stalled cannot redirect the fill.
    logic [IDX_W-1:0] fill_index;
    logic [TAG_W-1:0] fill_tag;
    assign fill_index = line_addr[LSB_W+IDX_W-1:LSB_W];
    assign fill_tag   = line_addr[ADDR_W-1:LSB_W+IDX_W];

    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, pc[1:0]};

    logic lookup_hit;
    assign lookup_hit = fetch_valid & valid[index] & (tag_arr[index] == tag);

    logic count_hit;
    logic count_miss;
    logic fill_now;
    assign fill_now = (state == REFILL) & mem.mem_ready;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        icache_stall = 1'b0;
        instruction  = '0;
        count_hit    = 1'b0;
        count_miss   = 1'b0;
        case (state)
            IDLE: begin
                if (lookup_hit) begin
                    count_hit   = 1'b1;
                    instruction = data_arr[index][offset];
                end else if (fetch_valid) begin
                    count_miss   = 1'b1;
                    icache_stall = 1'b1;
                    state_next   = REFILL;
                end
            end
            REFILL: begin
                icache_stall = 1'b1;
                if (mem.mem_ready) state_next = UPDATE;
            end
            UPDATE: begin
                icache_stall = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // While reset is held the fetch side must not see a stall.
        if (!reset) icache_stall = 1'b0;
    end

    // Request is a pure function of state so an asynchronous reset drops it
    // in the same instant.
    assign mem.mem_req  = (state == REFILL);
    assign mem.mem_addr = line_addr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            valid         <= '0;
            flush_pending <= 1'b0;
            line_addr     <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            state <= state_next;
            if (count_hit) hit_count <= hit_count + 32'd1;
            if (count_miss) begin
                miss_count <= miss_count + 32'd1;
                line_addr  <= {tag, index, {LSB_W{1'b0}}};
            end
            case (state)
                IDLE: begin
                    if (flush) valid <= '0;
                end
                REFILL: begin
                    if (flush) flush_pending <= 1'b1;
                    if (mem.mem_ready) valid[fill_index] <= 1'b1;
                end
                UPDATE: begin
                    // Pending flush lands after the refilled line was marked
                    // valid, so the replay lookup misses again.
                    if (flush || flush_pending) valid <= '0;
                    flush_pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; the valid bits
    // alone decide whether their contents are used.
    always_ff @(posedge clk) begin
        if (fill_now) begin
            tag_arr[fill_index] <= fill_tag;
            for (int w = 0; w < LINE_WORDS; w++) begin
                data_arr[fill_index][w] <= mem.mem_rdata[32*w +: 32];
            end
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

    logic        clk;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        icache_stall;
    logic        flush;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_direct_if #(.ADDR_W(32), .LINE_WORDS(4)) bus ();

    icache_direct #(.NUM_LINES(4), .LINE_WORDS(4), .ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_valid  (fetch_valid),
        .pc           (pc),
        .instruction  (instruction),
        .icache_stall (icache_stall),
        .flush        (flush),
        .mem          (bus),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Memory contents: the cold-miss program at 0x0, a pattern elsewhere.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        case (wa)
            32'h0: return 32'h0000_0013;
            32'h4: return 32'h0010_0093;
            32'h8: return 32'h0020_0113;
            32'hC: return 32'h0020_81B3;
            default: return 32'hC0DE_0000 ^ wa;
        endcase
    endfunction

    function automatic logic [127:0] line_at(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[32*i +: 32] = word_at(a + 32'(4*i));
        return l;
    endfunction

    // Memory responder: raises mem_ready in the mem_lat-th cycle of mem_req.
    logic         auto_mem = 1'b1;
    int           mem_lat  = 5;
    int           req_cycles = 0;
    int           req_seen   = 0;
    logic [31:0]  last_addr  = '0;
    logic         auto_ready = 1'b0;
    logic [127:0] auto_rdata = '0;
    logic         man_ready  = 1'b0;
    logic [127:0] man_rdata  = '0;

    assign bus.mem_ready = auto_mem ? auto_ready : man_ready;
    assign bus.mem_rdata = auto_mem ? auto_rdata : man_rdata;

    always @(negedge clk) begin
        if (bus.mem_req) begin
            req_seen++;
            req_cycles++;
            last_addr  = bus.mem_addr;
            auto_rdata = line_at(bus.mem_addr);
            auto_ready = (req_cycles == mem_lat);
        end else begin
            req_cycles = 0;
            auto_ready = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Fetch one pc until it is delivered; optionally pulse flush at the
    // negedge of the flush_at-th stalled cycle. Called at posedge+1.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_instr,
                            input int exp_stalls, input int flush_at, input string nm);
        int stalls;
        stalls = 0;
        fetch_valid = 1'b1;
        pc = a;
        @(negedge clk);
        while (icache_stall && stalls < 100) begin
            stalls++;
            if (stalls == flush_at) begin
                flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
            @(negedge clk);
        end
        check({nm, " stalls"}, 64'(stalls), 64'(exp_stalls));
        check({nm, " instr"}, {32'h0, instruction}, {32'h0, exp_instr});
        @(posedge clk);
        #1 fetch_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          stalls;
    } vec_t;

    vec_t seq_vec [3];
    int   stalls;
    int   req_before;

    initial begin
        seq_vec[0] = '{32'h4, 32'h0010_0093, 0};
        seq_vec[1] = '{32'h8, 32'h0020_0113, 0};
        seq_vec[2] = '{32'hC, 32'h0020_81B3, 0};

        reset = 1'b0;
        fetch_valid = 1'b1;
        pc = 32'h0;
        flush = 1'b0;

        // Reset state, with a lookup pending that would otherwise miss.
        #12;
        check("reset mem_req", {63'h0, bus.mem_req}, 64'h0);
        check("reset mem_addr", {32'h0, bus.mem_addr}, 64'h0);
        check("reset stall", {63'h0, icache_stall}, 64'h0);
        check("reset instr", {32'h0, instruction}, 64'h0);
        check("reset hit_count", {32'h0, hit_count}, 64'h0);
        check("reset miss_count", {32'h0, miss_count}, 64'h0);
        fetch_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss: 1 miss + 5 refill + 1 update cycles of stall.
        do_fetch(32'h0, 32'h0000_0013, 7, -1, "cold");
        check("cold mem_addr", {32'h0, last_addr}, 64'h0);
        check("cold miss_count", {32'h0, miss_count}, 64'd1);
        check("cold hit_count", {32'h0, hit_count}, 64'd1);

        // Sequential hits from the table.
        mem_lat = 1;
        req_before = req_seen;
        for (int i = 0; i < 3; i++) begin
            do_fetch(seq_vec[i].pc, seq_vec[i].instr, seq_vec[i].stalls, -1, $sformatf("seq%0d", i));
        end
        check("seq hit_count", {32'h0, hit_count}, 64'd4);
        check("seq no mem_req", 64'(req_seen - req_before), 64'h0);

        // Conflict eviction at index 0.
        do_fetch(32'h00, 32'h0000_0013, 0, -1, "evict hit0");
        do_fetch(32'h40, word_at(32'h40), 3, -1, "evict 40");
        check("evict addr 40", {32'h0, last_addr}, 64'h40);
        do_fetch(32'h00, 32'h0000_0013, 3, -1, "evict 00");
        check("evict addr 00", {32'h0, last_addr}, 64'h0);
        check("evict miss_count", {32'h0, miss_count}, 64'd3);
        check("evict hit_count", {32'h0, hit_count}, 64'd7);

        // Flush in IDLE: same-cycle lookup still sees the old contents.
        fetch_valid = 1'b1;
        pc = 32'h4;
        flush = 1'b1;
        @(negedge clk);
        check("flush same-cycle stall", {63'h0, icache_stall}, 64'h0);
        check("flush same-cycle instr", {32'h0, instruction}, 64'h0010_0093);
        @(posedge clk);
        #1 flush = 1'b0;
        fetch_valid = 1'b0;
        req_before = req_seen;
        do_fetch(32'h4, 32'h0010_0093, 3, -1, "post-flush");
        check("post-flush mem_req", 64'(req_seen - req_before), 64'd1);
        check("post-flush miss_count", {32'h0, miss_count}, 64'd4);

        // Flush during REFILL: replay misses again (2 x (1+3+1) stalls).
        mem_lat = 3;
        do_fetch(32'h10, word_at(32'h10), 10, 2, "refill flush");
        check("refill flush miss_count", {32'h0, miss_count}, 64'd6);

        // mem_ready while IDLE is ignored.
        auto_mem = 1'b0;
        man_rdata = '1;
        man_ready = 1'b1;
        @(posedge clk);
        #1 man_ready = 1'b0;
        @(negedge clk);
        check("idle ready mem_req", {63'h0, bus.mem_req}, 64'h0);
        check("idle ready stall", {63'h0, icache_stall}, 64'h0);
        @(posedge clk);
        #1 auto_mem = 1'b1;
        do_fetch(32'h10, word_at(32'h10), 0, -1, "idle ready hit");

        // pc change during REFILL: address stays latched, replay uses new pc.
        mem_lat = 4;
        fetch_valid = 1'b1;
        pc = 32'h80;
        stalls = 0;
        @(negedge clk);
        while (icache_stall && stalls < 100) begin
            stalls++;
            if (stalls == 2) pc = 32'h84;
            if (stalls == 4) check("pcchg mem_addr", {32'h0, bus.mem_addr}, 64'h80);
            @(negedge clk);
        end
        check("pcchg stalls", 64'(stalls), 64'd6);
        check("pcchg instr", {32'h0, instruction}, {32'h0, word_at(32'h84)});
        @(posedge clk);
        #1 fetch_valid = 1'b0;
        check("pcchg miss_count", {32'h0, miss_count}, 64'd7);

        // Reset mid-REFILL.
        auto_mem = 1'b0;
        fetch_valid = 1'b1;
        pc = 32'h20;
        @(posedge clk);
        @(negedge clk);
        check("rstmid in refill", {63'h0, bus.mem_req}, 64'h1);
        reset = 1'b0;
        #1;
        check("rstmid mem_req", {63'h0, bus.mem_req}, 64'h0);
        check("rstmid stall", {63'h0, icache_stall}, 64'h0);
        check("rstmid hit_count", {32'h0, hit_count}, 64'h0);
        check("rstmid miss_count", {32'h0, miss_count}, 64'h0);
        fetch_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        man_rdata = line_at(32'h20);
        man_ready = 1'b1;
        @(posedge clk);
        #1 man_ready = 1'b0;
        auto_mem = 1'b1;
        mem_lat = 1;
        do_fetch(32'h20, word_at(32'h20), 3, -1, "rstmid refetch");
        check("rstmid new miss", {32'h0, miss_count}, 64'd1);
        check("rstmid new hit", {32'h0, hit_count}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and main memory in the multi-cycle CPU.
- Fetch presents the program counter each cycle. A hit returns the instruction combinationally with no stall.
- A miss raises icache_stall, refills the whole line from memory over a request/ready handshake, then replays the lookup.
- Hit and miss counters support latency analysis in simulation.

Parameters:
- NUM_LINES, 4, number of cache lines; power of two, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of two.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_valid  in  1  fetch is requesting an instruction this cycle
- pc  in  ADDR_W  byte address of the instruction; bits [1:0] ignored
- instruction  out  32  instruction word; valid when fetch_valid=1 and icache_stall=0
- icache_stall  out  1  fetch must hold pc and retry
- flush  in  1  invalidate all lines (one-cycle pulse)
- mem_req  out  1  line refill request; held until mem_ready
- mem_addr  out  ADDR_W  line-aligned refill address
- mem_ready  in  1  one-cycle pulse; mem_rdata valid this cycle
- mem_rdata  in  32*LINE_WORDS  full line; word 0 is in bits [31:0]
- hit_count  out  32  lookups that hit
- miss_count  out  32  misses detected

Behaviour:
- Address split:
  - offset = pc[2+log2(LINE_WORDS)-1:2]
  - index = next log2(NUM_LINES) bits
  - tag = remaining upper bits
- Storage:
  - per line: valid bit, tag, LINE_WORDS data words
  - data is not reset; valid bits are reset to 0
- Reset (reset=0, asynchronous):
  - state=IDLE; all valid=0
  - mem_req=0, mem_addr=0, hit_count=0, miss_count=0
  - icache_stall forced to 0; instruction=0
- FSM states: IDLE, REFILL, UPDATE.
- IDLE:
  - hit = fetch_valid & valid[index] & (tag_array[index]==tag).
  - On hit: instruction = data[index][offset]; icache_stall=0; hit_count increments at the clock edge.
  - On a miss with fetch_valid=1: icache_stall=1 in the same cycle; miss_count increments; go to REFILL.
  - On that miss, latch the line address {tag,index,zeros}. mem_req rises in the first REFILL cycle.
  - fetch_valid=0: icache_stall=0; no counting.
- REFILL:
  - icache_stall=1; mem_req=1; mem_addr holds the latched line address, regardless of pc.
  - mem_ready=1: write mem_rdata to the latched index, set the tag, set valid=1, drop mem_req the next cycle, go to UPDATE.
- UPDATE:
  - icache_stall=1 for one cycle, then return to IDLE.
  - The re-lookup in IDLE hits, but is not recounted as a miss.
  - The replay hit increments hit_count.
- Miss latency:
  - miss cycle, plus N REFILL cycles (N = cycles until mem_ready, at least 1), plus 1 UPDATE cycle, then the hit cycle.
  - With mem_ready arriving in the first REFILL cycle: stall is high for 3 cycles and the instruction is delivered in the 4th.
- mem_ready outside REFILL is ignored.
- Flush:
  - In IDLE, clears all valid bits at the edge.
  - A lookup in the same cycle as flush uses the pre-flush contents.
  - During REFILL or UPDATE, flush is latched as pending. It is applied on entry to IDLE, after the refilled line was written. The replay lookup then misses and refills again.
- Counters wrap modulo 2^32.
- Eviction: a miss on an occupied index replaces that line unconditionally.
- A pc change while stalled does not alter the in-flight refill. The IDLE lookup after UPDATE uses the current pc.
- Reset asserted mid-REFILL:
  - mem_req drops immediately.
  - A partial line is never marked valid.
  - A late mem_ready after reset is ignored.

Test Plan:
- Cold miss:
  - Stimulus: reset release, fetch_valid=1, pc=0x00000000; memory returns line {0x13,0x00100093,0x00200113,0x002081B3} 5 cycles after mem_req.
  - Response: mem_addr=0x00000000; icache_stall high 7 cycles; instruction=0x13; miss_count=1, hit_count=1.
- Sequential hits:
  - Stimulus: pc=0x4, 0x8, 0xC after the cold fill.
  - Response: no stall; instructions 0x00100093, 0x00200113, 0x002081B3; hit_count=4; mem_req stays 0.
- Conflict eviction:
  - Stimulus: fill pc=0x00, then pc=0x40 (same index 0, different tag), then pc=0x00.
  - Response: each causes a miss with mem_addr 0x00, 0x40, 0x00 respectively; miss_count=3.
- Flush:
  - Stimulus: after a warm line, pulse flush in IDLE, then fetch pc=0x4.
  - Response: miss, mem_req=1.
  - Stimulus: flush pulse during REFILL.
  - Response: after UPDATE, the replay misses again; miss_count increments by 2.
- Handshake robustness:
  - Stimulus: mem_ready pulses while IDLE; pc changes during REFILL.
  - Response: no state change in IDLE; mem_addr stays latched.
- Reset mid-refill:
  - Stimulus: assert reset while REFILL is waiting; release; fetch the same pc.
  - Response: mem_req=0 immediately; counters 0; new miss occurs; no stale hit.
